mps_intr_sched: RTL and testbench

Interrupt scheduler for the multi-port serial (MPS) subsystem. It collects the level interrupt lines of PORT_NUM UART channels, latches them as pending, and presents one request at a time to the host interrupt line with the selected port index. It applies per-port masking, round-robin fairness and a programmable hold-off between consecutive requests. It sits between the per-port UART cores and the top-level `intr_request` pin of the MPS block.

---
 rtl/mps_intr_sched_if.sv | 27 ++
 rtl/mps_intr_sched.sv | 128 ++++++++++++
 tb/tb_mps_intr_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mps_intr_sched_if.sv
// Bus between the MPS UART cores / host side and the interrupt scheduler.
// The master side drives the interrupt sources and host controls; the slave
// side (the scheduler) returns the request, its port index and pending status.
`timescale 1ns/1ps
interface mps_intr_sched_if #(
  parameter int PORT_NUM  = 8,
  parameter int HOLDOFF_W = 16,
  parameter int PORT_W    = $clog2(PORT_NUM)
);
  logic [PORT_NUM-1:0]  port_irq;
  logic [PORT_NUM-1:0]  irq_mask;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 intr_ack;
  logic                 intr_request;
  logic [PORT_W-1:0]    intr_port;
  logic [PORT_NUM-1:0]  intr_pending;

  modport master (
    output port_irq, irq_mask, holdoff, intr_ack,
    input  intr_request, intr_port, intr_pending
  );

  modport slave (
    input  port_irq, irq_mask, holdoff, intr_ack,
    output intr_request, intr_port, intr_pending
  );
endinterface

// File: rtl/mps_intr_sched.sv
// MPS interrupt scheduler: latches per-port UART interrupts as pending and
// presents one request at a time to the host, choosing among enabled ports
// round-robin and enforcing a programmable idle gap after each acknowledge.
`timescale 1ns/1ps
module mps_intr_sched #(
  parameter int PORT_NUM  = 8,
  parameter int HOLDOFF_W = 16,
  parameter int PORT_W    = $clog2(PORT_NUM)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  mps_intr_sched_if.slave       irq_bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  state_t               state, state_nxt;
  logic [PORT_NUM-1:0]  irq_p0;
  logic [PORT_NUM-1:0]  pending;
  logic [PORT_NUM-1:0]  elig;
  logic [PORT_NUM-1:0]  clr;
  logic [PORT_W-1:0]    last, last_nxt;
  logic [PORT_W-1:0]    port_q, port_nxt;
  logic [PORT_W-1:0]    sel_idx;
  logic                 sel_found;
  logic                 req_q, req_nxt;
  logic                 ack_ok;
  logic [HOLDOFF_W-1:0] cnt, cnt_nxt;
  int                   rr_idx;

  assign ack_ok = (state == ASSERT) && irq_bus.intr_ack;
  assign elig   = pending & irq_bus.irq_mask;

  assign irq_bus.intr_request = req_q;
  assign irq_bus.intr_port    = port_q;
  assign irq_bus.intr_pending = pending;

  // One-hot clear of the acknowledged port's pending bit.
  always_comb begin
    clr = '0;
    if (ack_ok) clr[port_q] = 1'b1;
  end

  // Round-robin pick: scan from last+1 upward with wrap; scanning backwards
  // lets the nearest eligible port overwrite any farther one.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_idx    = 0;
    for (int k = PORT_NUM; k >= 1; k--) begin
      rr_idx = int'(last) + k;
      if (rr_idx >= PORT_NUM) rr_idx = rr_idx - PORT_NUM;
      if (elig[rr_idx[PORT_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = rr_idx[PORT_W-1:0];
      end
    end
  end

  // Input sampling stage and pending latch; a new set wins over the clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq_p0  <= '0;
      pending <= '0;
    end else begin
      irq_p0  <= irq_bus.port_irq;
      pending <= (pending & ~clr) | irq_p0;
    end
  end

  // State and scheduler registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      port_q <= '0;
      cnt    <= '0;
      last   <= PORT_W'(PORT_NUM - 1);
    end else begin
      state  <= state_nxt;
      req_q  <= req_nxt;
      port_q <= port_nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = ASSERT;
      ASSERT:  if (irq_bus.intr_ack)
                 state_nxt = (irq_bus.holdoff == '0) ? IDLE : HOLDOFF;
      HOLDOFF: if (cnt <= HOLDOFF_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath updates; the port is frozen while a request is up,
  // and the counter parks at 1 so it can never wrap.
  always_comb begin
    req_nxt  = req_q;
    port_nxt = port_q;
    cnt_nxt  = cnt;
    last_nxt = last;
    case (state)
      IDLE: begin
        if (sel_found) begin
          req_nxt  = 1'b1;
          port_nxt = sel_idx;
        end
      end
      ASSERT: begin
        if (irq_bus.intr_ack) begin
          req_nxt  = 1'b0;
          last_nxt = port_q;
          if (irq_bus.holdoff != '0) cnt_nxt = irq_bus.holdoff;
        end
      end
      HOLDOFF: begin
        if (cnt > HOLDOFF_W'(1)) cnt_nxt = cnt - HOLDOFF_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mps_intr_sched.sv
// Scoreboard bench for mps_intr_sched: the stimulus process pushes expected
// request rises, falls and status snapshots (tagged with the clock edge they
// belong to); a monitor on the falling clock edge pops and compares them.
`timescale 1ns/1ps
module tb_mps_intr_sched;
  localparam int PORT_NUM  = 8;
  localparam int HOLDOFF_W = 16;

  typedef struct { int cyc; int val; } evt_t;
  typedef struct { int cyc; int id; logic req; int port; logic [7:0] pend; } stat_t;

  logic aclk;
  logic aresetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stat_id = 0;
  bit   done = 1'b0;
  int   rr[3] = '{0, 2, 7};

  evt_t  rise_q[$];
  evt_t  fall_q[$];
  stat_t stat_q[$];

  mps_intr_sched_if #(.PORT_NUM(PORT_NUM), .HOLDOFF_W(HOLDOFF_W)) irq_bus ();

  mps_intr_sched #(.PORT_NUM(PORT_NUM), .HOLDOFF_W(HOLDOFF_W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .irq_bus (irq_bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic exp_rise(input int c, input int p);
    evt_t e;
    e.cyc = c; e.val = p;
    rise_q.push_back(e);
  endtask

  task automatic exp_fall(input int c, input int pend);
    evt_t e;
    e.cyc = c; e.val = pend;
    fall_q.push_back(e);
  endtask

  // port < 0 means the port index is not meaningful (request low).
  task automatic exp_stat(input int c, input logic r, input int p, input logic [7:0] pend);
    stat_t s;
    s.cyc = c; s.id = stat_id; s.req = r; s.port = p; s.pend = pend;
    stat_id++;
    stat_q.push_back(s);
  endtask

  // Stimulus.
  initial begin
    int c;
    aresetn = 1'b0;
    irq_bus.port_irq = '0;
    irq_bus.irq_mask = 8'hFF;
    irq_bus.holdoff  = '0;
    irq_bus.intr_ack = 1'b0;
    tick(2);

    // Reset held: inputs toggled, outputs stay at reset values.
    irq_bus.port_irq = 8'hFF;
    tick(1); exp_stat(cyc, 1'b0, 0, 8'h00);
    tick(2); exp_stat(cyc, 1'b0, 0, 8'h00);
    irq_bus.port_irq = 8'h00;
    tick(1);
    aresetn = 1'b1;
    tick(4); exp_stat(cyc, 1'b0, 0, 8'h00);

    // Single port 3, level dropped before acknowledge.
    c = cyc;
    irq_bus.port_irq = 8'h08;
    exp_rise(c + 3, 3);
    tick(3); exp_stat(cyc, 1'b1, 3, 8'h08);
    irq_bus.port_irq = 8'h00;
    tick(2); exp_stat(cyc, 1'b1, 3, 8'h08);
    irq_bus.intr_ack = 1'b1;
    exp_fall(cyc + 1, 8'h00);
    tick(1);
    irq_bus.intr_ack = 1'b0;
    tick(2); exp_stat(cyc, 1'b0, -1, 8'h00);

    // Round-robin over ports 0, 2, 7 with immediate acknowledges.
    aresetn = 1'b0; tick(1); aresetn = 1'b1; tick(1);
    c = cyc;
    irq_bus.port_irq = 8'h85;
    for (int i = 0; i < 7; i++) exp_rise(c + 3 + 2 * i, rr[i % 3]);
    for (int i = 0; i < 6; i++) exp_fall(c + 4 + 2 * i, 8'h85);
    tick(3);
    for (int i = 0; i < 6; i++) begin
      irq_bus.intr_ack = 1'b1; tick(1);
      irq_bus.intr_ack = 1'b0; tick(1);
    end
    tick(1);
    irq_bus.port_irq = 8'h00;
    aresetn = 1'b0;
    exp_fall(cyc, 8'h00);
    exp_stat(cyc, 1'b0, 0, 8'h00);
    tick(1); aresetn = 1'b1; tick(1);

    // Masking: port 0 latched but masked, then enabled while port 1 is up.
    c = cyc;
    irq_bus.irq_mask = 8'h02;
    irq_bus.port_irq = 8'h03;
    exp_rise(c + 3, 1);
    tick(3); exp_stat(cyc, 1'b1, 1, 8'h03);
    irq_bus.irq_mask = 8'h03;
    tick(2); exp_stat(cyc, 1'b1, 1, 8'h03);
    irq_bus.intr_ack = 1'b1;
    exp_fall(cyc + 1, 8'h03);
    exp_rise(cyc + 2, 0);
    tick(1);
    irq_bus.intr_ack = 1'b0;
    tick(2);
    irq_bus.port_irq = 8'h00;
    aresetn = 1'b0;
    exp_fall(cyc, 8'h00);
    exp_stat(cyc, 1'b0, 0, 8'h00);
    tick(1); aresetn = 1'b1; tick(1);

    // Hold-off of 5, then 0 (holdoff changed after the ack is ignored).
    irq_bus.irq_mask = 8'hFF;
    c = cyc;
    irq_bus.holdoff  = 16'd5;
    irq_bus.port_irq = 8'h12;
    exp_rise(c + 3, 1);
    tick(3);
    irq_bus.intr_ack = 1'b1;
    exp_fall(c + 4, 8'h12);
    exp_rise(c + 10, 4);
    tick(1);
    irq_bus.intr_ack = 1'b0;
    irq_bus.holdoff  = 16'd0;
    tick(2); exp_stat(cyc, 1'b0, -1, 8'h12);
    tick(4);
    irq_bus.intr_ack = 1'b1;
    exp_fall(c + 11, 8'h12);
    exp_rise(c + 12, 1);
    tick(1);
    irq_bus.intr_ack = 1'b0;
    irq_bus.holdoff  = 16'd3;
    tick(1);

    // Reset during HOLDOFF.
    irq_bus.intr_ack = 1'b1;
    exp_fall(cyc + 1, 8'h12);
    tick(1);
    irq_bus.intr_ack = 1'b0;
    tick(1);
    irq_bus.port_irq = 8'h01;
    aresetn = 1'b0;
    exp_stat(cyc, 1'b0, 0, 8'h00);
    tick(1);
    aresetn = 1'b1;
    exp_rise(cyc + 3, 0);
    tick(3);

    // Reset during ASSERT.
    tick(1);
    aresetn = 1'b0;
    exp_fall(cyc, 8'h00);
    exp_stat(cyc, 1'b0, 0, 8'h00);
    tick(1);
    aresetn = 1'b1;
    exp_rise(cyc + 3, 0);
    tick(3);
    irq_bus.holdoff  = 16'd0;
    irq_bus.port_irq = 8'h00;
    tick(2);
    irq_bus.intr_ack = 1'b1;
    exp_fall(cyc + 1, 8'h00);
    tick(1);
    irq_bus.intr_ack = 1'b0;
    tick(3); exp_stat(cyc, 1'b0, -1, 8'h00);
    tick(1);
    done = 1'b1;
  end

  // Monitor / scoreboard.
  initial begin
    evt_t  e;
    stat_t s;
    logic  prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge aclk);
      if (irq_bus.intr_request === 1'b1 && !prev_req) begin
        checks++;
        if (rise_q.size() == 0) begin
          errors++;
          $display("FAIL rise_unexpected cyc=%0d port=%0d, required no request", cyc, irq_bus.intr_port);
        end else begin
          e = rise_q.pop_front();
          if (cyc != e.cyc || int'(irq_bus.intr_port) != e.val) begin
            errors++;
            $display("FAIL rise got cyc=%0d port=%0d, required cyc=%0d port=%0d",
                     cyc, irq_bus.intr_port, e.cyc, e.val);
          end
        end
      end
      if (irq_bus.intr_request !== 1'b1 && prev_req) begin
        checks++;
        if (fall_q.size() == 0) begin
          errors++;
          $display("FAIL fall_unexpected cyc=%0d, required request still high", cyc);
        end else begin
          e = fall_q.pop_front();
          if (cyc != e.cyc || int'(irq_bus.intr_pending) != e.val) begin
            errors++;
            $display("FAIL fall got cyc=%0d pending=%02h, required cyc=%0d pending=%02h",
                     cyc, irq_bus.intr_pending, e.cyc, e.val);
          end
        end
      end
      while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
        s = stat_q.pop_front();
        checks++;
        if (irq_bus.intr_request !== s.req ||
            (s.port >= 0 && int'(irq_bus.intr_port) != s.port) ||
            irq_bus.intr_pending !== s.pend) begin
          errors++;
          $display("FAIL stat%0d cyc=%0d got req=%b port=%0d pend=%02h, required req=%b port=%0d pend=%02h",
                   s.id, cyc, irq_bus.intr_request, irq_bus.intr_port, irq_bus.intr_pending,
                   s.req, s.port, s.pend);
        end
      end
      prev_req = (irq_bus.intr_request === 1'b1);
      if (done) begin
        while (rise_q.size() > 0) begin
          e = rise_q.pop_front();
          checks++; errors++;
          $display("FAIL rise_missing got none, required cyc=%0d port=%0d", e.cyc, e.val);
        end
        while (fall_q.size() > 0) begin
          e = fall_q.pop_front();
          checks++; errors++;
          $display("FAIL fall_missing got none, required cyc=%0d", e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  // Guard against a stimulus sequence that never completes.
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d, required completion before time limit", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
